// File: rtl/sync_generator_if.sv
// Video timing bus between a counter source and sync_generator.
// master drives the counter position and strobes, slave returns the decoded timing.
interface sync_generator_if;
  logic        en;
  logic [11:0] h_count;
  logic [11:0] v_count;
  logic        err_clr;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;
  logic        timing_err;

  modport master (
    output en, h_count, v_count, err_clr,
    input  hsync, vsync, de, pix_x, pix_y, line_start, frame_start, frame_count, timing_err
  );

  modport slave (
    input  en, h_count, v_count, err_clr,
    output hsync, vsync, de, pix_x, pix_y, line_start, frame_start, frame_count, timing_err
  );
endinterface

// File: rtl/sync_generator.sv
// Sync generator: decodes h/v counter positions into hsync/vsync/de, pixel
// coordinates and frame/line pulses through a 2-stage en-qualified pipeline,
// and flags out-of-range or non-sequential counter input.
module sync_generator #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BACK   = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FRONT  = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 20,
  parameter bit SYNC_POL = 1'b1
) (
  input logic            clk,
  input logic            rst,
  sync_generator_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // 13-bit thresholds so a 12-bit count plus one never wraps into a false match
  localparam logic [12:0] H_ACT     = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_LO = 13'(H_ACTIVE + H_FRONT);
  localparam logic [12:0] H_SYNC_HI = 13'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [12:0] H_END     = 13'(H_TOTAL);
  localparam logic [12:0] H_LAST    = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_ACT     = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_LO = 13'(V_ACTIVE + V_FRONT);
  localparam logic [12:0] V_SYNC_HI = 13'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [12:0] V_END     = 13'(V_TOTAL);
  localparam logic [12:0] V_LAST    = 13'(V_TOTAL - 1);

  logic [12:0] h_in, v_in, h_prev, v_prev, h_exp, v_exp;
  logic        illegal, h_act, v_act, h_syn, v_syn, seq_err;

  // stage 1 registers: sampled position plus decoded flags
  logic [11:0] h1, v1;
  logic        hs1, vs1, de1, ls1, fs1, err1;
  logic        seen;     // a sample has been taken since reset
  logic        fs_seen;  // first frame_start since reset has been emitted

  // region decode of the incoming sample and sequence check against the previous one
  always_comb begin
    h_in    = {1'b0, bus.h_count};
    v_in    = {1'b0, bus.v_count};
    h_prev  = {1'b0, h1};
    v_prev  = {1'b0, v1};
    illegal = (h_in >= H_END) || (v_in >= V_END);
    h_act   = h_in < H_ACT;
    v_act   = v_in < V_ACT;
    h_syn   = (h_in >= H_SYNC_LO) && (h_in < H_SYNC_HI);
    v_syn   = (v_in >= V_SYNC_LO) && (v_in < V_SYNC_HI);
    if (h_prev == H_LAST) begin
      h_exp = '0;
      v_exp = (v_prev == V_LAST) ? '0 : v_prev + 13'd1;
    end else begin
      h_exp = h_prev + 13'd1;
      v_exp = v_prev;
    end
    seq_err = seen && ((h_in != h_exp) || (v_in != v_exp));
  end

  // stage 1: capture position and flags; illegal samples decode as back porch
  always_ff @(posedge clk) begin
    if (rst) begin
      h1   <= '0;
      v1   <= '0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      de1  <= 1'b0;
      ls1  <= 1'b0;
      fs1  <= 1'b0;
      err1 <= 1'b0;
      seen <= 1'b0;
    end else if (bus.en) begin
      h1   <= bus.h_count;
      v1   <= bus.v_count;
      hs1  <= h_syn && !illegal;
      vs1  <= v_syn && !illegal;
      de1  <= h_act && v_act && !illegal;
      ls1  <= (h_in == '0) && v_act && !illegal;
      fs1  <= (h_in == '0) && (v_in == '0);
      err1 <= illegal || seq_err;
      seen <= 1'b1;
    end
  end

  // stage 2: registered outputs; pulses only live in cycles where this stage loads
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.hsync       <= ~SYNC_POL;
      bus.vsync       <= ~SYNC_POL;
      bus.de          <= 1'b0;
      bus.pix_x       <= '0;
      bus.pix_y       <= '0;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_count <= '0;
      fs_seen         <= 1'b0;
    end else if (bus.en) begin
      bus.hsync       <= hs1 ? SYNC_POL : ~SYNC_POL;
      bus.vsync       <= vs1 ? SYNC_POL : ~SYNC_POL;
      bus.de          <= de1;
      bus.pix_x       <= de1 ? h1[10:0] : '0;
      bus.pix_y       <= de1 ? v1[9:0] : '0;
      bus.line_start  <= ls1;
      bus.frame_start <= fs1;
      if (fs1) begin
        if (fs_seen) bus.frame_count <= bus.frame_count + 16'd1;
        fs_seen <= 1'b1;
      end
    end else begin
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end
  end

  // sticky error flag; a new error in the same cycle beats err_clr
  always_ff @(posedge clk) begin
    if (rst)                  bus.timing_err <= 1'b0;
    else if (bus.en && err1)  bus.timing_err <= 1'b1;
    else if (bus.err_clr)     bus.timing_err <= 1'b0;
  end
endmodule

// File: tb/tb_sync_generator.sv
// Randomized bench for sync_generator on a shrunken raster, compared every
// cycle against a sample-history reference model.
module tb_sync_generator;
  localparam int HA = 16, HF = 4, HS = 3, HB = 5;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam bit POL = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_generator_if bus();

  sync_generator #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {int h; int v; bit bad;} samp_t;
  samp_t q[$];  // samples accepted since reset, newest last

  int  n_chk = 0, n_fail = 0;
  bit  m_hs, m_vs, m_de, m_ls, m_fs, m_te, m_fs_seen;
  int  m_px, m_py, m_fc;
  int  hc, vc;
  int  de_cnt, ls_cnt, fs_cnt, hs_cnt, vs_cnt, step_no, first_fs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: outputs reflect the second-newest accepted sample
  task automatic model(input bit r, input bit e, input int h, input int v, input bit c);
    samp_t s, o, p;
    int eh, ev;
    bit ill, newerr;
    if (r) begin
      q.delete();
      m_hs = !POL; m_vs = !POL; m_de = 0; m_px = 0; m_py = 0;
      m_ls = 0; m_fs = 0; m_fc = 0; m_te = 0; m_fs_seen = 0;
      return;
    end
    newerr = 0;
    m_ls = 0;
    m_fs = 0;
    if (e) begin
      s.h = h; s.v = v; s.bad = (h >= HT) || (v >= VT);
      if (q.size() > 0) begin
        p = q[$];
        if (p.h == HT - 1) begin
          eh = 0;
          ev = (p.v == VT - 1) ? 0 : p.v + 1;
        end else begin
          eh = p.h + 1;
          ev = p.v;
        end
        if (h != eh || v != ev) s.bad = 1;
      end
      q.push_back(s);
      if (q.size() > 2) void'(q.pop_front());
      if (q.size() == 2) begin
        o = q[0];
        ill = (o.h >= HT) || (o.v >= VT);
        m_de = !ill && o.h < HA && o.v < VA;
        m_hs = (!ill && o.h >= HA + HF && o.h < HA + HF + HS) ? POL : !POL;
        m_vs = (!ill && o.v >= VA + VF && o.v < VA + VF + VS) ? POL : !POL;
        m_px = m_de ? o.h : 0;
        m_py = m_de ? o.v : 0;
        m_ls = !ill && o.h == 0 && o.v < VA;
        m_fs = o.h == 0 && o.v == 0;
        if (m_fs) begin
          if (m_fs_seen) m_fc = (m_fc + 1) % 65536;
          m_fs_seen = 1;
        end
        newerr = o.bad;
      end else begin
        m_hs = !POL; m_vs = !POL; m_de = 0; m_px = 0; m_py = 0;
      end
    end
    if (newerr) m_te = 1;
    else if (c) m_te = 0;
  endtask

  task automatic step(input bit r, input bit e, input int h, input int v, input bit c);
    rst = r;
    bus.en = e;
    bus.h_count = 12'(h);
    bus.v_count = 12'(v);
    bus.err_clr = c;
    @(posedge clk);
    model(r, e, h, v, c);
    #1;
    step_no++;
    chk("hsync", bus.hsync, m_hs);
    chk("vsync", bus.vsync, m_vs);
    chk("de", bus.de, m_de);
    chk("pix_x", bus.pix_x, m_px);
    chk("pix_y", bus.pix_y, m_py);
    chk("line_start", bus.line_start, m_ls);
    chk("frame_start", bus.frame_start, m_fs);
    chk("frame_count", bus.frame_count, m_fc);
    chk("timing_err", bus.timing_err, m_te);
    if (bus.de) de_cnt++;
    if (bus.line_start) ls_cnt++;
    if (bus.hsync == POL) hs_cnt++;
    if (bus.vsync == POL) vs_cnt++;
    if (bus.frame_start) begin
      fs_cnt++;
      if (first_fs == 0) first_fs = step_no;
    end
  endtask

  task automatic adv();
    if (hc == HT - 1) begin
      hc = 0;
      vc = (vc == VT - 1) ? 0 : vc + 1;
    end else hc++;
  endtask

  task automatic go(input bit e, input bit c);
    step(1'b0, e, hc, vc, c);
    if (e) adv();
  endtask

  task automatic clr_stats();
    de_cnt = 0; ls_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; step_no = 0; first_fs = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hsync"}, bus.hsync, !POL);
    chk({tag, "_vsync"}, bus.vsync, !POL);
    chk({tag, "_de"}, bus.de, 0);
    chk({tag, "_pix"}, {bus.pix_x, bus.pix_y}, 0);
    chk({tag, "_pulses"}, {bus.line_start, bus.frame_start}, 0);
    chk({tag, "_fc"}, bus.frame_count, 0);
    chk({tag, "_err"}, bus.timing_err, 0);
  endtask

  initial begin
    bit r, e, c;
    rst = 1'b1;
    bus.en = 1'b0; bus.h_count = '0; bus.v_count = '0; bus.err_clr = 1'b0;
    clr_stats();

    // reset, including rst together with en/err_clr
    step(1, 0, 0, 0, 0);
    step(1, 1, 5, 5, 1);
    step(1, 1, 7, 2, 0);
    chk_reset_vals("reset");

    // two full frames from (0,0), en every cycle
    hc = 0; vc = 0;
    clr_stats();
    for (int i = 0; i < 2 * FT + 1; i++) go(1, 0);
    chk("two_fr_de_cnt", de_cnt, 2 * HA * VA);
    chk("two_fr_ls_cnt", ls_cnt, 2 * VA);
    chk("two_fr_fs_cnt", fs_cnt, 2);
    chk("two_fr_hs_cnt", hs_cnt, 2 * VT * HS);
    chk("two_fr_vs_cnt", vs_cnt, 2 * VS * HT);
    chk("first_fs_latency", first_fs, 2);
    chk("two_fr_fc", bus.frame_count, 1);
    chk("two_fr_err", bus.timing_err, 0);

    // en toggling 1,0,1,0 across more than a frame
    clr_stats();
    for (int i = 0; i < 2 * FT; i++) go(i % 2 == 0, 0);
    chk("toggle_fs_cnt", fs_cnt, 1);
    chk("toggle_err", bus.timing_err, 0);

    // illegal h, then recovery and clear
    step(0, 1, 1700, vc, 0);
    go(1, 0);
    chk("illegal_err", bus.timing_err, 1);
    chk("illegal_de", bus.de, 0);
    for (int i = 0; i < 4; i++) go(1, 0);
    go(1, 1);
    chk("illegal_clr", bus.timing_err, 0);

    // skip from h=10 to h=12
    for (int i = 0; i < HT && hc != 10; i++) go(1, 0);
    go(1, 0);
    step(0, 1, 12, vc, 0);
    hc = 13;
    go(1, 0);
    chk("skip_err", bus.timing_err, 1);
    go(1, 0);
    go(1, 1);
    chk("skip_clr", bus.timing_err, 0);

    // reset mid-frame, then restart at an arbitrary position
    hc = HA / 2; vc = VA / 2;
    for (int i = 0; i < 5; i++) go(1, 0);
    step(1, 1, hc, vc, 0);
    chk_reset_vals("midrst");
    hc = $urandom_range(HT - 1);
    vc = $urandom_range(VT - 1);
    for (int i = 0; i < 2 * HT; i++) go(1, 0);
    chk("restart_err", bus.timing_err, 0);

    // err_clr in the same cycle a new error arrives
    step(0, 1, 3000, vc, 0);
    go(1, 1);
    chk("set_wins", bus.timing_err, 1);
    for (int i = 0; i < 3; i++) go(1, 0);
    go(1, 1);
    chk("set_wins_clr", bus.timing_err, 0);

    // random soak: en gaps, clears, resets, jumps and garbage samples
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(199) == 0);
      e = ($urandom_range(3) != 0);
      c = ($urandom_range(29) == 0);
      if ($urandom_range(99) == 0) begin
        step(r, e, int'($urandom_range(4095)), int'($urandom_range(4095)), c);
      end else begin
        if ($urandom_range(49) == 0) begin
          hc = $urandom_range(HT - 1);
          vc = $urandom_range(VT - 1);
        end
        step(r, e, hc, vc, c);
        if (e) adv();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
